// File: rtl/fetch_target_queue.sv
// Fetch target queue: circular buffer of predicted fetch blocks between BPU and IFU, retiring resolved blocks as FTB updates.
// Latency: an entry written in cycle N can be issued to the IFU in cycle N+1; a committed head block raises its update two cycles after the commit.
// Backpressure: o_ftq_rdy drops when full or on squash; fetch waits on i_fetch_rdy; each update holds until i_update_finished.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   i_pred_vld/o_ftq_rdy/i_pred_ftqInfo        enqueue from BPU s2
//   o_fetch_vld/i_fetch_rdy/o_fetch_*          in-order fetch block issue to IFU
//   i_commit_vld/i_commit_ftqIdx/_taken/_target  backend resolution of a fetched block
//   i_squash_vld/i_squash_ftqIdx                backend redirect; entries after idx are dropped
//   o_update_vld/i_update_finished/o_BPupdateInfo  in-order FTB training writes

package ftq_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    logic [XLEN-1:0] endAddr;
    logic            taken;
    logic [XLEN-1:0] targetAddr;
    logic            hit_on_ftb;
    logic [1:0]      branch_type;
    logic [1:0]      ftb_counter;
  } ftqInfo_t;

  typedef struct packed {
    logic            hit;
    logic            mispred;
    logic [1:0]      counter;
    logic [1:0]      branch_type;
    logic            taken;
    logic [XLEN-1:0] target;
  } ftb_update_t;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    ftb_update_t     ftb_update;
  } BPupdateInfo_t;
endpackage

module fetch_target_queue
  import ftq_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_pred_vld,
  output logic                o_ftq_rdy,
  input  ftqInfo_t            i_pred_ftqInfo,
  output logic                o_fetch_vld,
  input  logic                i_fetch_rdy,
  output logic [XLEN-1:0]     o_fetch_startAddr,
  output logic [XLEN-1:0]     o_fetch_endAddr,
  output logic [IDXW-1:0]     o_fetch_ftqIdx,
  input  logic                i_commit_vld,
  input  logic [IDXW-1:0]     i_commit_ftqIdx,
  input  logic                i_commit_taken,
  input  logic [XLEN-1:0]     i_commit_target,
  input  logic                i_squash_vld,
  input  logic [IDXW-1:0]     i_squash_ftqIdx,
  output logic                o_update_vld,
  input  logic                i_update_finished,
  output BPupdateInfo_t       o_BPupdateInfo
);
  localparam int PW = IDXW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   head, fptr, tail;
  logic [PW-1:0]   count, fetched;
  logic [IDXW-1:0] head_idx, fptr_idx, tail_idx;
  logic            full, empty;

  ftqInfo_t        ent [DEPTH];
  logic [XLEN-1:0] res_target [DEPTH];
  logic [DEPTH-1:0] res_taken;
  logic [DEPTH-1:0] done;

  logic [0:0]      state;
  BPupdateInfo_t   upd;

  assign head_idx = head[IDXW-1:0];
  assign fptr_idx = fptr[IDXW-1:0];
  assign tail_idx = tail[IDXW-1:0];
  assign count    = tail - head;
  assign fetched  = fptr - head;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (head == tail);

  assign o_ftq_rdy   = rst && !full && !i_squash_vld;
  assign o_fetch_vld = rst && (fptr != tail) && !i_squash_vld;

  logic enq, fire;
  assign enq  = i_pred_vld && o_ftq_rdy;
  assign fire = o_fetch_vld && i_fetch_rdy;

  assign o_fetch_startAddr = ent[fptr_idx].startAddr;
  assign o_fetch_endAddr   = ent[fptr_idx].endAddr;
  assign o_fetch_ftqIdx    = fptr_idx;

  // Commits are only honoured for blocks already handed to the IFU.
  logic [IDXW-1:0] commit_rel;
  logic            commit_ok;
  assign commit_rel = i_commit_ftqIdx - head_idx;
  assign commit_ok  = rst && i_commit_vld && ({1'b0, commit_rel} < fetched);

  // Squash position measured from head so the wrap bit is reconstructed correctly.
  logic [IDXW-1:0] sq_off;
  logic [PW-1:0]   sq_rel, sq_ptr;
  assign sq_off = i_squash_ftqIdx - head_idx;
  assign sq_rel = {1'b0, sq_off} + PW'(1);
  assign sq_ptr = head + sq_rel;

  // Update payload derived from the head entry and its resolved outcome.
  ftqInfo_t h;
  logic     h_taken;
  logic [XLEN-1:0] h_target;
  logic [1:0] ctr_nxt;
  BPupdateInfo_t upd_nxt;
  assign h        = ent[head_idx];
  assign h_taken  = res_taken[head_idx];
  assign h_target = res_target[head_idx];

  always_comb begin
    ctr_nxt = h.ftb_counter;
    if (h_taken) begin
      if (h.ftb_counter != 2'd3) ctr_nxt = h.ftb_counter + 2'd1;
    end else begin
      if (h.ftb_counter != 2'd0) ctr_nxt = h.ftb_counter - 2'd1;
    end
    upd_nxt                        = '0;
    upd_nxt.startAddr              = h.startAddr;
    upd_nxt.ftb_update.hit         = h.hit_on_ftb;
    upd_nxt.ftb_update.mispred     = (h.taken != h_taken) || (h_taken && (h.targetAddr != h_target));
    upd_nxt.ftb_update.counter     = ctr_nxt;
    upd_nxt.ftb_update.branch_type = h.branch_type;
    upd_nxt.ftb_update.taken       = h_taken;
    upd_nxt.ftb_update.target      = h_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      fptr  <= '0;
      tail  <= '0;
      done  <= '0;
      state <= IDLE;
      upd   <= '0;
    end else begin
      if (i_squash_vld) begin
        tail <= sq_ptr;
        if (fetched > sq_rel) fptr <= sq_ptr;
      end else begin
        if (enq)  tail <= tail + PW'(1);
        if (fire) fptr <= fptr + PW'(1);
      end

      if (enq)       done[tail_idx]        <= 1'b0;
      if (commit_ok) done[i_commit_ftqIdx] <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty && done[head_idx]) begin
            upd   <= upd_nxt;
            state <= REQ;
          end
        end
        default: begin
          // Squash never touches head, so the in-flight update is always retired here.
          if (i_update_finished) begin
            head  <= head + PW'(1);
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and done[].
  always_ff @(posedge clk) begin
    if (enq) ent[tail_idx] <= i_pred_ftqInfo;
    if (commit_ok) begin
      res_taken[i_commit_ftqIdx]  <= i_commit_taken;
      res_target[i_commit_ftqIdx] <= i_commit_target;
    end
  end

  assign o_update_vld   = rst && (state == REQ);
  assign o_BPupdateInfo = rst ? upd : '0;

endmodule

// File: tb/tb_fetch_target_queue.sv
module tb_fetch_target_queue;
  import ftq_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pred_vld;
  logic          o_ftq_rdy;
  ftqInfo_t      i_pred_ftqInfo;
  logic          o_fetch_vld;
  logic          i_fetch_rdy;
  logic [31:0]   o_fetch_startAddr;
  logic [31:0]   o_fetch_endAddr;
  logic [3:0]    o_fetch_ftqIdx;
  logic          i_commit_vld;
  logic [3:0]    i_commit_ftqIdx;
  logic          i_commit_taken;
  logic [31:0]   i_commit_target;
  logic          i_squash_vld;
  logic [3:0]    i_squash_ftqIdx;
  logic          o_update_vld;
  logic          i_update_finished;
  BPupdateInfo_t o_BPupdateInfo;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_target_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_pred_vld(i_pred_vld), .o_ftq_rdy(o_ftq_rdy), .i_pred_ftqInfo(i_pred_ftqInfo),
    .o_fetch_vld(o_fetch_vld), .i_fetch_rdy(i_fetch_rdy),
    .o_fetch_startAddr(o_fetch_startAddr), .o_fetch_endAddr(o_fetch_endAddr),
    .o_fetch_ftqIdx(o_fetch_ftqIdx),
    .i_commit_vld(i_commit_vld), .i_commit_ftqIdx(i_commit_ftqIdx),
    .i_commit_taken(i_commit_taken), .i_commit_target(i_commit_target),
    .i_squash_vld(i_squash_vld), .i_squash_ftqIdx(i_squash_ftqIdx),
    .o_update_vld(o_update_vld), .i_update_finished(i_update_finished),
    .o_BPupdateInfo(o_BPupdateInfo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic ftqInfo_t mk(input logic [31:0] a, input logic [1:0] ctr, input logic pt);
    ftqInfo_t f;
    f.startAddr   = a;
    f.endAddr     = a + 32'h1c;
    f.taken       = pt;
    f.targetAddr  = a + 32'h100;
    f.hit_on_ftb  = 1'b1;
    f.branch_type = 2'b01;
    f.ftb_counter = ctr;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_pred_vld = 0; i_pred_ftqInfo = '0; i_fetch_rdy = 0;
    i_commit_vld = 0; i_commit_ftqIdx = '0; i_commit_taken = 0; i_commit_target = '0;
    i_squash_vld = 0; i_squash_ftqIdx = '0; i_update_finished = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step(); step();
    rst = 1;
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] ctr, input logic pt);
    i_pred_vld = 1; i_pred_ftqInfo = mk(a, ctr, pt);
    step();
    i_pred_vld = 0;
  endtask

  task automatic fetch_n(input int n);
    i_fetch_rdy = 1;
    repeat (n) step();
    i_fetch_rdy = 0;
  endtask

  task automatic commit(input logic [3:0] idx, input logic tk, input logic [31:0] tg);
    i_commit_vld = 1; i_commit_ftqIdx = idx; i_commit_taken = tk; i_commit_target = tg;
    step();
    i_commit_vld = 0;
  endtask

  task automatic wait_upd(output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_update_vld) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; i_pred_vld = 1; i_pred_ftqInfo = mk(32'h1234, 2'd1, 1'b0); i_fetch_rdy = 1;
    step(); step();
    tests_run++; if (o_ftq_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy: got %b want 0", o_ftq_rdy); end
    tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_vld: got %b want 0", o_fetch_vld); end
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_update_vld: got %b want 0", o_update_vld); end
    tests_run++; if (o_BPupdateInfo !== '0) begin tests_failed++; $display("FAIL reset_info: got %h want 0", o_BPupdateInfo); end
    idle_inputs();
    rst = 1; #1;
    tests_run++; if (o_ftq_rdy !== 1'b1) begin tests_failed++; $display("FAIL release_rdy: got %b want 1", o_ftq_rdy); end
    tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL release_empty: got %b want 0", o_fetch_vld); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      i_pred_vld = 1; i_pred_ftqInfo = mk(32'h1000 + i * 32'h20, 2'd0, 1'b0);
      #1;
      tests_run++;
      if (o_ftq_rdy !== (i < 16)) begin tests_failed++; $display("FAIL fill_rdy[%0d]: got %b want %b", i, o_ftq_rdy, (i < 16)); end
      step();
    end
    i_pred_vld = 0; i_fetch_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      tests_run++;
      if (o_fetch_vld !== 1'b1 || o_fetch_startAddr !== 32'h1000 + i * 32'h20) begin
        tests_failed++; $display("FAIL fill_drain[%0d]: got vld=%b addr=%h want vld=1 addr=%h", i, o_fetch_vld, o_fetch_startAddr, 32'h1000 + i * 32'h20);
      end
      step();
    end
    i_fetch_rdy = 0; #1;
    tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL fill_17th_dropped: got vld=%b want 0", o_fetch_vld); end
  endtask

  task automatic test_order();
    logic [31:0] addrs [3];
    addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0020; addrs[2] = 32'h8000_0040;
    do_reset();
    i_fetch_rdy = 1;
    for (int c = 0; c < 5; c++) begin
      i_pred_vld = (c < 3);
      if (c < 3) i_pred_ftqInfo = mk(addrs[c], 2'd0, 1'b0);
      #1;
      if (c == 0 || c == 4) begin
        tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL order_vld_c%0d: got %b want 0", c, o_fetch_vld); end
      end else begin
        tests_run++;
        if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'(c - 1) || o_fetch_startAddr !== addrs[c - 1] || o_fetch_endAddr !== addrs[c - 1] + 32'h1c) begin
          tests_failed++; $display("FAIL order_c%0d: got vld=%b idx=%0d addr=%h end=%h want vld=1 idx=%0d addr=%h end=%h", c, o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr, o_fetch_endAddr, c - 1, addrs[c - 1], addrs[c - 1] + 32'h1c);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h2000 + i * 32'h20, 2'd0, 1'b0);
    fetch_n(6);
    i_squash_vld = 1; i_squash_ftqIdx = 4'd3; i_fetch_rdy = 1;
    i_pred_vld = 1; i_pred_ftqInfo = mk(32'hDEAD_0000, 2'd0, 1'b0);
    #1;
    tests_run++; if (o_ftq_rdy !== 1'b0) begin tests_failed++; $display("FAIL squash_rdy: got %b want 0", o_ftq_rdy); end
    tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL squash_fetch_vld: got %b want 0", o_fetch_vld); end
    step();
    idle_inputs(); #1;
    tests_run++; if (o_fetch_vld !== 1'b0) begin tests_failed++; $display("FAIL squash_fptr_eq_tail: got %b want 0", o_fetch_vld); end
    tests_run++; if (o_ftq_rdy !== 1'b1) begin tests_failed++; $display("FAIL squash_rdy_after: got %b want 1", o_ftq_rdy); end
    push(32'h5000, 2'd0, 1'b0); #1;
    tests_run++;
    if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd4 || o_fetch_startAddr !== 32'h5000) begin
      tests_failed++; $display("FAIL squash_next: got vld=%b idx=%0d addr=%h want vld=1 idx=4 addr=5000", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr);
    end
  endtask

  task automatic test_commit_order();
    do_reset();
    push(32'h100, 2'd2, 1'b1);
    push(32'h200, 2'd0, 1'b0);
    commit(4'd0, 1'b1, 32'h9000);   // not fetched yet, must be ignored
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL commit_unfetched_ignored[%0d]: got %b want 0", i, o_update_vld); end
      step();
    end
    fetch_n(2);
    commit(4'd1, 1'b0, 32'h0);
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL commit_ooo_wait: got %b want 0", o_update_vld); end
    commit(4'd0, 1'b1, 32'h9000);
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL commit_latch_cycle: got %b want 0", o_update_vld); end
    step();
    tests_run++;
    if (o_update_vld !== 1'b1 || o_BPupdateInfo.startAddr !== 32'h100 || o_BPupdateInfo.ftb_update.counter !== 2'd3 ||
        o_BPupdateInfo.ftb_update.taken !== 1'b1 || o_BPupdateInfo.ftb_update.target !== 32'h9000 || o_BPupdateInfo.ftb_update.mispred !== 1'b1) begin
      tests_failed++; $display("FAIL upd0: got vld=%b info=%h want vld=1 start=100 ctr=3 taken=1 tgt=9000 mispred=1", o_update_vld, o_BPupdateInfo);
    end
    i_update_finished = 1; step(); i_update_finished = 0;
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL upd_gap: got %b want 0", o_update_vld); end
    step();
    tests_run++;
    if (o_update_vld !== 1'b1 || o_BPupdateInfo.startAddr !== 32'h200 || o_BPupdateInfo.ftb_update.counter !== 2'd0 ||
        o_BPupdateInfo.ftb_update.taken !== 1'b0 || o_BPupdateInfo.ftb_update.mispred !== 1'b0) begin
      tests_failed++; $display("FAIL upd1: got vld=%b info=%h want vld=1 start=200 ctr=0 taken=0 mispred=0", o_update_vld, o_BPupdateInfo);
    end
    i_update_finished = 1; step(); i_update_finished = 0;
    step();
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL upd_drained: got %b want 0", o_update_vld); end
  endtask

  task automatic test_update_backpressure();
    BPupdateInfo_t exp;
    bit ok;
    exp = '0;
    exp.startAddr = 32'h300;
    exp.ftb_update.hit = 1'b1;
    exp.ftb_update.mispred = 1'b1;       // predicted target 0x400, actual 0x7000
    exp.ftb_update.counter = 2'd2;
    exp.ftb_update.branch_type = 2'b01;
    exp.ftb_update.taken = 1'b1;
    exp.ftb_update.target = 32'h7000;
    do_reset();
    push(32'h300, 2'd1, 1'b1);
    fetch_n(1);
    commit(4'd0, 1'b1, 32'h7000);
    wait_upd(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_timeout: got no update want update"); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (o_update_vld !== 1'b1 || o_BPupdateInfo !== exp) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got vld=%b info=%h want vld=1 info=%h", k, o_update_vld, o_BPupdateInfo, exp);
      end
      step();
    end
    i_update_finished = 1; step(); i_update_finished = 0;
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL bp_no_reissue[%0d]: got %b want 0", k, o_update_vld); end
      step();
    end
    for (int i = 0; i < 15; i++) push(32'h4000 + i * 32'h20, 2'd0, 1'b0);
    #1;
    tests_run++; if (o_ftq_rdy !== 1'b1) begin tests_failed++; $display("FAIL bp_head_once_15: got rdy=%b want 1", o_ftq_rdy); end
    push(32'h4400, 2'd0, 1'b0); #1;
    tests_run++; if (o_ftq_rdy !== 1'b0) begin tests_failed++; $display("FAIL bp_head_once_16: got rdy=%b want 0", o_ftq_rdy); end
  endtask

  task automatic test_wrap();
    int base;
    bit ok;
    logic [31:0] a;
    do_reset();
    base = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) push(32'h10000 + (base + k) * 32'h20, 2'(k), k[0]);
      i_fetch_rdy = 1;
      for (int k = 0; k < 12; k++) begin
        a = 32'h10000 + (base + k) * 32'h20;
        #1;
        tests_run++;
        if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'((base + k) % 16) || o_fetch_startAddr !== a) begin
          tests_failed++; $display("FAIL wrap_fetch[%0d]: got vld=%b idx=%0d addr=%h want vld=1 idx=%0d addr=%h", base + k, o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr, (base + k) % 16, a);
        end
        step();
      end
      i_fetch_rdy = 0;
      for (int k = 0; k < 12; k++) commit(4'((base + k) % 16), k[1], 32'h3000);
      for (int k = 0; k < 12; k++) begin
        wait_upd(ok);
        a = 32'h10000 + (base + k) * 32'h20;
        tests_run++;
        if (!ok || o_BPupdateInfo.startAddr !== a) begin
          tests_failed++; $display("FAIL wrap_update[%0d]: got ok=%b addr=%h want ok=1 addr=%h", base + k, ok, o_BPupdateInfo.startAddr, a);
        end
        i_update_finished = 1; step(); i_update_finished = 0;
      end
      #1;
      tests_run++;
      if (o_fetch_vld !== 1'b0 || o_ftq_rdy !== 1'b1) begin
        tests_failed++; $display("FAIL wrap_empty_r%0d: got vld=%b rdy=%b want vld=0 rdy=1", r, o_fetch_vld, o_ftq_rdy);
      end
      base += 12;
    end
    for (int i = 0; i < 16; i++) begin
      #1;
      tests_run++; if (o_ftq_rdy !== 1'b1) begin tests_failed++; $display("FAIL wrap_fill_rdy[%0d]: got %b want 1", i, o_ftq_rdy); end
      push(32'h20000 + i * 32'h20, 2'd0, 1'b0);
    end
    #1;
    tests_run++; if (o_ftq_rdy !== 1'b0) begin tests_failed++; $display("FAIL wrap_full: got rdy=%b want 0", o_ftq_rdy); end
    tests_run++;
    if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd0 || o_fetch_startAddr !== 32'h20000) begin
      tests_failed++; $display("FAIL wrap_full_head: got vld=%b idx=%0d addr=%h want vld=1 idx=0 addr=20000", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr);
    end
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    do_reset();
    push(32'h600, 2'd1, 1'b0);
    fetch_n(1);
    commit(4'd0, 1'b1, 32'h800);
    wait_upd(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midreset_req: got no update want update"); end
    rst = 0; i_update_finished = 1; #1;
    tests_run++;
    if (o_update_vld !== 1'b0 || o_BPupdateInfo !== '0 || o_ftq_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_during: got vld=%b info=%h rdy=%b want 0/0/0", o_update_vld, o_BPupdateInfo, o_ftq_rdy);
    end
    step();
    rst = 1; i_update_finished = 0; #1;
    tests_run++;
    if (o_update_vld !== 1'b0 || o_fetch_vld !== 1'b0 || o_ftq_rdy !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_after: got upd=%b fetch=%b rdy=%b want 0/0/1", o_update_vld, o_fetch_vld, o_ftq_rdy);
    end
    step(); step();
    tests_run++; if (o_update_vld !== 1'b0) begin tests_failed++; $display("FAIL midreset_idle: got %b want 0", o_update_vld); end
    push(32'h700, 2'd0, 1'b0); #1;
    tests_run++;
    if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd0 || o_fetch_startAddr !== 32'h700) begin
      tests_failed++; $display("FAIL midreset_restart: got vld=%b idx=%0d addr=%h want vld=1 idx=0 addr=700", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_fill();
    test_order();
    test_squash();
    test_commit_order();
    test_update_backpressure();
    test_wrap();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
